// File: rtl/hpu_pkg.sv
// hpu_pkg: shared source-buffer constants and loader state type
package hpu_pkg;
  localparam int SRC_BANK_WORDS = 1024;
  localparam int SRC_BEATS_MAX = 512;
  typedef enum logic {LD_WAIT, LD_FILL} ld_state_t;
endpackage

// File: rtl/src_bank_ctrl.sv
// src_bank_ctrl: per-bank full flags; a set beats a release aimed at the same bank
module src_bank_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_v,
  input  logic       set_bank,
  input  logic       rel_v,
  input  logic       rel_bank,
  output logic [1:0] bank_full
);
  logic [1:0] set_m, rel_m;
  assign set_m = set_v ? 2'b01 << set_bank : 2'b00;
  assign rel_m = rel_v ? 2'b01 << rel_bank : 2'b00;
  always_ff @(posedge clk)
    bank_full <= rst ? 2'b00 : set_m | (bank_full & ~rel_m);
endmodule

// File: rtl/src_loader.sv
// src_loader: packs 64-bit upstream beats into a double-banked source buffer.
// Optional SRC_LOADER_LEN_EN adds per-bank frame length outputs.
module src_loader
  import hpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        src_v,
  output logic [10:0] src_a,
  output logic [63:0] src_d,
  input  logic        rel_v,
  input  logic        rel_bank,
  output logic [1:0]  bank_full,
  output logic        err
`ifdef SRC_LOADER_LEN_EN
  ,
  output logic [9:0]  frame_len0,
  output logic [9:0]  frame_len1
`endif
);
  localparam int BW = $clog2(SRC_BEATS_MAX);
  ld_state_t state, state_n;
  logic wr_bank, acc, at_max, fend;
  logic [BW-1:0] beat_cnt;
  logic [1:0] free_m;
  assign s_ready = state == LD_FILL;
  assign acc = s_valid & s_ready;
  assign at_max = beat_cnt == BW'(SRC_BEATS_MAX - 1);
  assign fend = acc & (s_last | at_max);
  // a bank released this very cycle already counts as free
  assign free_m = ~bank_full | (rel_v ? 2'b01 << rel_bank : 2'b00);
  always_ff @(posedge clk)
    state <= rst ? LD_FILL : state_n;
  always_comb begin
    state_n = state;
    if (state == LD_WAIT) state_n = free_m[wr_bank] ? LD_FILL : LD_WAIT;
    else if (fend) state_n = free_m[~wr_bank] ? LD_FILL : LD_WAIT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_bank  <= 1'b0;
      beat_cnt <= '0;
      err      <= 1'b0;
      src_v    <= 1'b0;
      src_a    <= '0;
      src_d    <= '0;
    end else begin
      src_v <= acc;
      if (acc) begin
        src_a <= {wr_bank, beat_cnt, 1'b0};
        src_d <= s_data;
      end
      if (fend) begin
        wr_bank  <= ~wr_bank;
        beat_cnt <= '0;
      end else if (acc) beat_cnt <= beat_cnt + 1'b1;
      if (acc & at_max & ~s_last) err <= 1'b1;
    end
  src_bank_ctrl u_bank_ctrl (
    .clk      (clk),
    .rst      (rst),
    .set_v    (fend),
    .set_bank (wr_bank),
    .rel_v    (rel_v),
    .rel_bank (rel_bank),
    .bank_full(bank_full)
  );
`ifdef SRC_LOADER_LEN_EN
  logic [9:0] len;
  assign len = {1'b0, beat_cnt} + 10'd1;
  always_ff @(posedge clk)
    if (rst) begin
      frame_len0 <= '0;
      frame_len1 <= '0;
    end else if (fend) begin
      if (wr_bank) frame_len1 <= len;
      else frame_len0 <= len;
    end
`endif
endmodule

// File: tb/tb_src_loader.sv
// tb_src_loader: directed stimulus, per-cycle model compare plus literal checks
module tb_src_loader;
  import hpu_pkg::*;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, rel_v = 0, rel_bank = 0;
  logic [63:0] s_data = '0;
  logic s_ready, src_v, err;
  logic [10:0] src_a;
  logic [63:0] src_d;
  logic [1:0] bank_full;
`ifdef SRC_LOADER_LEN_EN
  logic [9:0] frame_len0, frame_len1;
`endif
  int checks = 0, errors = 0;

  src_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .src_v(src_v), .src_a(src_a), .src_d(src_d),
    .rel_v(rel_v), .rel_bank(rel_bank), .bank_full(bank_full), .err(err)
`ifdef SRC_LOADER_LEN_EN
    , .frame_len0(frame_len0), .frame_len1(frame_len1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: a bank takes beats while it is free; a frame ends on last or the 512th beat.
  logic m_on = 0, m_bank, m_err, m_ready, e_v, ma, mf;
  logic [1:0] m_full, mnf;
  int m_cnt;
  int m_len [2];
  logic [10:0] e_a;
  logic [63:0] e_d;
  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_full = 0; m_bank = 0; m_cnt = 0; m_err = 0; m_ready = 1; e_v = 0;
      m_len[0] = 0; m_len[1] = 0;
    end else if (m_on) begin
      ma = s_valid && m_ready;
      e_v = ma;
      if (ma) begin
        e_a = 11'(int'(m_bank) * SRC_BANK_WORDS + 2 * m_cnt);
        e_d = s_data;
      end
      mf = ma && (s_last || m_cnt == SRC_BEATS_MAX - 1);
      mnf = m_full;
      if (rel_v) mnf[rel_bank] = 1'b0;
      if (mf) begin
        mnf[m_bank] = 1'b1;
        if (!s_last) m_err = 1;
        m_len[m_bank] = m_cnt + 1;
        m_bank = !m_bank;
        m_cnt = 0;
      end else if (ma) m_cnt++;
      m_full = mnf;
      m_ready = !m_full[m_bank];
    end
  end

  always @(negedge clk)
    if (m_on && !rst) begin
      chk("s_ready", s_ready, m_ready);
      chk("bank_full", bank_full, m_full);
      chk("err", err, m_err);
      chk("src_v", src_v, e_v);
      if (e_v) begin
        chk("src_a", src_a, e_a);
        chk("src_d", src_d, e_d);
      end
`ifdef SRC_LOADER_LEN_EN
      chk("frame_len0", frame_len0, 10'(m_len[0]));
      chk("frame_len1", frame_len1, 10'(m_len[1]));
`endif
    end

  // Leaves s_valid high so consecutive calls stream back-to-back.
  task automatic beat(input logic [63:0] d, input logic l, input logic [10:0] ea);
    int n = 0;
    s_valid = 1; s_data = d; s_last = l;
    while (!s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("accept_timeout", s_ready, 1);
    @(negedge clk);
    chk("src_a_lit", src_a, ea);
  endtask

  task automatic idle(input int n);
    s_valid = 0; s_last = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rel(input logic b);
    s_valid = 0; s_last = 0; rel_v = 1; rel_bank = b;
    @(negedge clk);
    rel_v = 0;
  endtask

  task automatic do_rst();
    s_valid = 0; s_last = 0; rel_v = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_bank_full", bank_full, 2'b00);
    chk("rst_err", err, 0);
    chk("rst_src_v", src_v, 0);
    chk("rst_src_a", src_a, 0);
    chk("rst_src_d", src_d, 0);
    // four-beat frame into bank 0
    for (int i = 0; i < 4; i++) beat(64'(i + 1), i == 3, 11'(2 * i));
    chk("f1_full", bank_full, 2'b01);
    beat(64'h10, 0, 11'h400);
    beat(64'h11, 1, 11'h402);
    chk("f2_full", bank_full, 2'b11);
    chk("f2_stall", s_ready, 0);
    idle(3);
    chk("f2_stall_hold", s_ready, 0);
    rel(0);
    chk("rel0_ready", s_ready, 1);
    chk("rel0_full", bank_full, 2'b10);
    beat(64'h20, 0, 11'h000);
    beat(64'h21, 0, 11'h002);
    beat(64'h22, 1, 11'h004);
    idle(1);
    chk("f3_full", bank_full, 2'b11);
    rel(1);
    chk("rel1_full", bank_full, 2'b01);
    // frame end on bank 1 with bank 0 released in the same cycle
    rel_v = 1; rel_bank = 0;
    beat(64'h30, 1, 11'h400);
    rel_v = 0;
    chk("cross_full", bank_full, 2'b10);
    chk("cross_ready", s_ready, 1);
    // frame end and release on the same bank: set wins
    rel_v = 1; rel_bank = 0;
    beat(64'h40, 1, 11'h000);
    rel_v = 0;
    idle(2);
    chk("setwin_full", bank_full, 2'b11);
    rel(1);
    rel(0);
    rel(0);
    chk("rel_all_full", bank_full, 2'b00);
    // reset mid-frame on bank 1 discards it
    beat(64'h50, 0, 11'h400);
    beat(64'h51, 0, 11'h402);
    beat(64'h52, 0, 11'h404);
    do_rst();
    chk("midrst_full", bank_full, 2'b00);
    beat(64'h60, 1, 11'h000);
    idle(1);
    chk("midrst_next_full", bank_full, 2'b01);
    // overlong frame forced to end at 512 beats
    do_rst();
    for (int i = 0; i < 512; i++) beat(64'hA000 + 64'(i), 0, 11'(2 * i));
    chk("ovf_err", err, 1);
    chk("ovf_full", bank_full, 2'b01);
    beat(64'h999, 1, 11'h400);
    idle(5);
    chk("ovf_err_sticky", err, 1);
    chk("ovf_full2", bank_full, 2'b11);
`ifdef SRC_LOADER_LEN_EN
    do_rst();
    for (int i = 0; i < 7; i++) beat(64'(i), i == 6, 11'(2 * i));
    idle(1);
    chk("len0_7", frame_len0, 10'd7);
    chk("len1_0", frame_len1, 10'd0);
    for (int i = 0; i < 3; i++) beat(64'(i), i == 2, 11'h400 + 11'(2 * i));
    idle(1);
    chk("len1_3", frame_len1, 10'd3);
    chk("len0_keep", frame_len0, 10'd7);
`endif
    do_rst();
    chk("err_cleared", err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
